// File: rtl/sat_pkg.sv
// sat_pkg: shared trail entry/level types, FSM states and the null variable id
package sat_pkg;
  localparam int LEVEL_W = 16;
  localparam logic [31:0] VAR_NONE = '0;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef struct packed {
    logic [31:0] var_id;
    logic        value;
    level_t      level;
  } trail_entry_t;
  typedef enum logic {IDLE, UNWIND} state_t;
endpackage

// File: rtl/trail_mem.sv
// trail_mem: single-write single-read synchronous array (clk; we/waddr/wdata write port; raddr in, rdata registered out)
module trail_mem #(
  parameter int W = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/trail_stack.sv
// trail_stack: LIFO assignment trail with decision levels; push_* in / assign_* echo out, bt_* backtrack in / clear_* unwind out, cur_level/trail_count/overflow/bad_var status
module trail_stack
  import sat_pkg::*;
#(
  parameter int MAX_VARS = 256,
  parameter int DEPTH = 256,
  parameter int LVL_W = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_all,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_var,
  input  logic             push_value,
  input  logic             push_is_decision,
  output logic             assign_valid,
  output logic [31:0]      assign_var,
  output logic             assign_value,
  input  logic             bt_valid,
  output logic             bt_ready,
  input  logic [LVL_W-1:0] bt_level,
  output logic             bt_done,
  output logic             clear_valid,
  output logic [31:0]      clear_var,
  output logic             clear_value,
  output logic [LVL_W-1:0] cur_level,
  output logic [CW-1:0]    trail_count,
  output logic             overflow,
  output logic             bad_var
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);
  state_t state;
  logic [CW-1:0] tgt_count;
  logic [CW-1:0] level_start [DEPTH+1];
  trail_entry_t wr_entry, rd_entry;
  logic push_ok, var_ok, lvl_sat, do_write, do_dec, bt_ok, bt_noop, last;
  logic [LVL_W-1:0] new_level;
  logic [AW-1:0] raddr;
  always_comb begin
    push_ready = state == IDLE && !bt_valid && trail_count < CW'(DEPTH);
    bt_ready = state == IDLE;
    push_ok = push_valid && push_ready;
    var_ok = push_var != VAR_NONE && push_var <= 32'(MAX_VARS);
    lvl_sat = &cur_level;
    do_write = push_ok && var_ok && !(push_is_decision && lvl_sat);
    do_dec = do_write && push_is_decision;
    new_level = do_dec ? cur_level + 1'b1 : cur_level;
    bt_ok = bt_valid && bt_ready;
    bt_noop = bt_level >= cur_level;
    last = trail_count - 1'b1 == tgt_count;
    raddr = AW'(state == UNWIND ? trail_count - 2'd2 : trail_count - 1'b1);
    wr_entry = '{var_id: push_var, value: push_value, level: level_t'(new_level)};
    clear_valid = state == UNWIND;
    clear_var = clear_valid ? rd_entry.var_id : VAR_NONE;
    clear_value = clear_valid && rd_entry.value;
  end
  trail_mem #(.W($bits(trail_entry_t)), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (AW'(trail_count)),
    .wdata (wr_entry),
    .raddr (raddr),
    .rdata (rd_entry)
  );
  always_ff @(posedge clk) begin
    if (do_dec) level_start[SW'(new_level)] <= trail_count;
  end
  always_ff @(posedge clk) begin
    if (!reset_n || clear_all) begin
      state <= IDLE;
      trail_count <= '0;
      cur_level <= '0;
      overflow <= 1'b0;
      assign_valid <= 1'b0;
      assign_var <= VAR_NONE;
      assign_value <= 1'b0;
      bt_done <= 1'b0;
      bad_var <= 1'b0;
      tgt_count <= '0;
    end else begin
      assign_valid <= do_write;
      if (do_write) begin
        assign_var <= push_var;
        assign_value <= push_value;
        trail_count <= trail_count + 1'b1;
        cur_level <= new_level;
      end
      bad_var <= push_ok && !var_ok;
      overflow <= overflow || (push_ok && var_ok && push_is_decision && lvl_sat);
      bt_done <= (bt_ok && bt_noop) || (clear_valid && last);
      if (bt_ok && !bt_noop) begin
        state <= UNWIND;
        tgt_count <= level_start[SW'(bt_level + 1'b1)];
      end
      if (clear_valid) begin
        trail_count <= trail_count - 1'b1;
        if (last) begin
          state <= IDLE;
          cur_level <= LVL_W'(rd_entry.level - 1'b1);
        end
      end
    end
  end
endmodule

// File: tb/tb_trail_stack.sv
// tb_trail_stack: table-driven pushes plus hand sequences for backtrack, full, overflow and reset corners
module tb_trail_stack;
  localparam int MV = 40, D = 8, LW = 2, CW = $clog2(D) + 1;
  logic clk = 1'b0, reset_n = 1'b0, clear_all = 1'b0;
  logic push_valid = 1'b0, push_value = 1'b0, push_is_decision = 1'b0, bt_valid = 1'b0;
  logic [31:0] push_var = '0;
  logic [LW-1:0] bt_level = '0;
  logic push_ready, assign_valid, assign_value, bt_ready, bt_done, clear_valid, clear_value, overflow, bad_var;
  logic [31:0] assign_var, clear_var;
  logic [LW-1:0] cur_level;
  logic [CW-1:0] trail_count;
  trail_stack #(.MAX_VARS(MV), .DEPTH(D), .LVL_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .clear_all(clear_all),
    .push_valid(push_valid), .push_ready(push_ready), .push_var(push_var),
    .push_value(push_value), .push_is_decision(push_is_decision),
    .assign_valid(assign_valid), .assign_var(assign_var), .assign_value(assign_value),
    .bt_valid(bt_valid), .bt_ready(bt_ready), .bt_level(bt_level), .bt_done(bt_done),
    .clear_valid(clear_valid), .clear_var(clear_var), .clear_value(clear_value),
    .cur_level(cur_level), .trail_count(trail_count), .overflow(overflow), .bad_var(bad_var)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit clr; bit [31:0] v; bit val; bit dec; bit acc; bit bad; int cnt; int lvl;
  } vec_t;
  typedef struct { bit is_clr; bit [31:0] v; bit val; } ev_t;
  ev_t sb[$];
  ev_t e;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl [13] = '{
    '{0, 5,  1, 1, 1, 0, 1, 1},
    '{0, 9,  0, 0, 1, 0, 2, 1},
    '{0, 0,  1, 0, 0, 1, 2, 1},
    '{0, 41, 0, 0, 0, 1, 2, 1},
    '{0, 40, 1, 0, 1, 0, 3, 1},
    '{1, 0,  0, 0, 0, 0, 0, 0},
    '{0, 1,  1, 1, 1, 0, 1, 1},
    '{0, 10, 0, 0, 1, 0, 2, 1},
    '{0, 2,  1, 1, 1, 0, 3, 2},
    '{0, 20, 0, 0, 1, 0, 4, 2},
    '{0, 3,  1, 1, 1, 0, 5, 3},
    '{0, 30, 0, 0, 1, 0, 6, 3},
    '{0, 7,  1, 1, 0, 0, 6, 3}
  };
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_push(input logic [31:0] v, input logic val, input logic dec);
    push_valid = 1'b1; push_var = v; push_value = val; push_is_decision = dec;
    sb.push_back('{1'b0, v, val});
    step;
    push_valid = 1'b0;
  endtask
  task automatic do_clr;
    clear_all = 1'b1;
    step;
    clear_all = 1'b0;
  endtask
  task automatic do_bt(input logic [LW-1:0] lvl, output int n, output logic rdy1);
    bt_valid = 1'b1; bt_level = lvl;
    step;
    bt_valid = 1'b0; push_valid = 1'b0;
    rdy1 = bt_ready;
    n = 1;
    while (!bt_done && n < 20) begin
      step;
      n++;
    end
  endtask
  always @(negedge clk) begin
    if (assign_valid || clear_valid) begin
      n_cmp++;
      if (assign_valid && clear_valid) begin
        n_bad++;
        $display("FAIL out_overlap: got assign and clear together want one");
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got clear=%0d var=%0d want nothing", clear_valid, clear_valid ? clear_var : assign_var);
      end else begin
        e = sb.pop_front();
        if (e.is_clr !== clear_valid || e.v !== (clear_valid ? clear_var : assign_var) || e.val !== (clear_valid ? clear_value : assign_value)) begin
          n_bad++;
          $display("FAIL out_event: got clear=%0d var=%0d val=%0d want clear=%0d var=%0d val=%0d",
                   clear_valid, clear_valid ? clear_var : assign_var, clear_valid ? clear_value : assign_value, e.is_clr, e.v, e.val);
        end
      end
    end
  end
  initial begin
    int n;
    logic rdy1;
    step;
    step;
    chk("rst_count", trail_count, 0);
    chk("rst_level", cur_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_assign_valid", assign_valid, 0);
    chk("rst_clear_valid", clear_valid, 0);
    chk("rst_bt_done", bt_done, 0);
    chk("rst_bad_var", bad_var, 0);
    reset_n = 1'b1;
    step;
    chk("rst_push_ready", push_ready, 1);
    chk("rst_bt_ready", bt_ready, 1);
    for (int i = 0; i < 13; i++) begin
      clear_all = tbl[i].clr;
      push_valid = !tbl[i].clr;
      push_var = tbl[i].v; push_value = tbl[i].val; push_is_decision = tbl[i].dec;
      if (tbl[i].acc) sb.push_back('{1'b0, tbl[i].v, tbl[i].val});
      step;
      clear_all = 1'b0; push_valid = 1'b0;
      chk($sformatf("vec%0d_assign_valid", i), assign_valid, tbl[i].acc);
      chk($sformatf("vec%0d_bad_var", i), bad_var, tbl[i].bad);
      chk($sformatf("vec%0d_count", i), trail_count, tbl[i].cnt);
      chk($sformatf("vec%0d_level", i), cur_level, tbl[i].lvl);
    end
    chk("overflow_set", overflow, 1);
    bt_valid = 1'b1; bt_level = 1; push_valid = 1'b1; push_var = 11; push_is_decision = 1'b0;
    #1;
    chk("prio_push_ready", push_ready, 0);
    chk("prio_bt_ready", bt_ready, 1);
    sb.push_back('{1'b1, 30, 0});
    sb.push_back('{1'b1, 3, 1});
    sb.push_back('{1'b1, 20, 0});
    sb.push_back('{1'b1, 2, 1});
    do_bt(1, n, rdy1);
    chk("ml_bt_ready_busy", rdy1, 0);
    chk("ml_latency", n, 5);
    chk("ml_level", cur_level, 1);
    chk("ml_count", trail_count, 2);
    chk("ml_overflow_sticky", overflow, 1);
    step;
    chk("ml_done_pulse", bt_done, 0);
    chk("ml_bt_ready", bt_ready, 1);
    do_push(4, 1, 1);
    chk("nop_pre_level", cur_level, 2);
    do_bt(2, n, rdy1);
    chk("nop_latency", n, 1);
    chk("nop_level", cur_level, 2);
    chk("nop_count", trail_count, 3);
    chk("nop_bt_ready", rdy1, 1);
    step;
    chk("nop_done_pulse", bt_done, 0);
    do_bt(3, n, rdy1);
    chk("nop_above_latency", n, 1);
    chk("nop_above_count", trail_count, 3);
    do_clr;
    chk("clr_overflow", overflow, 0);
    do_push(12, 1, 0);
    do_push(13, 0, 1);
    do_push(14, 1, 0);
    sb.push_back('{1'b1, 14, 1});
    sb.push_back('{1'b1, 13, 0});
    do_bt(0, n, rdy1);
    chk("l0_latency", n, 3);
    chk("l0_count", trail_count, 1);
    chk("l0_level", cur_level, 0);
    do_clr;
    for (int i = 1; i <= D; i++) do_push(20 + i, i[0], 0);
    chk("full_count", trail_count, D);
    push_valid = 1'b1; push_var = 33; push_value = 1'b1; push_is_decision = 1'b0;
    #1;
    chk("full_push_ready", push_ready, 0);
    step;
    push_valid = 1'b0;
    chk("full_hold_count", trail_count, D);
    chk("full_no_assign", assign_valid, 0);
    step;
    do_clr;
    do_push(1, 1, 1);
    do_push(2, 0, 0);
    do_push(3, 1, 1);
    do_push(4, 0, 0);
    chk("mid_pre_count", trail_count, 4);
    sb.push_back('{1'b1, 4, 0});
    sb.push_back('{1'b1, 3, 1});
    bt_valid = 1'b1; bt_level = 0;
    step;
    bt_valid = 1'b0;
    chk("mid_first_clear", clear_valid, 1);
    step;
    chk("mid_second_clear", clear_var, 3);
    reset_n = 1'b0;
    step;
    chk("mid_clear_valid", clear_valid, 0);
    chk("mid_count", trail_count, 0);
    chk("mid_level", cur_level, 0);
    chk("mid_bt_done", bt_done, 0);
    chk("mid_clear_var", clear_var, 0);
    reset_n = 1'b1;
    step;
    chk("mid_post_bt_done", bt_done, 0);
    chk("mid_post_bt_ready", bt_ready, 1);
    step;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trail_stack.md
Name: trail_stack

Overview:
- Assignment trail and decision-level manager sitting directly downstream of the variable decision engine.
- Accepts decisions from the decision engine and implied assignments from BCP, records each on a LIFO trail tagged with its decision level, and drives the decision engine's assign bookkeeping.
- On backtrack it unwinds the trail one entry per cycle, emitting clear_var to the decision engine until the target level is reached.
- Runs in one clock domain.

Parameters:
- MAX_VARS, 256, number of variables; legal variable ids are 1..MAX_VARS.
- DEPTH, 256, trail capacity in entries.
- LVL_W, 16, width of decision-level counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- clear_all  in  1  synchronous flush; same effect as reset, no clears emitted.
- push_valid  in  1  new assignment offered.
- push_ready  out  1  trail can accept this cycle.
- push_var  in  32  variable id, 1-based.
- push_value  in  1  assigned polarity.
- push_is_decision  in  1  1 = decision (opens a new level), 0 = implied at current level.
- assign_valid  out  1  registered echo of an accepted push, to the decision engine.
- assign_var  out  32  variable id of that push.
- assign_value  out  1  polarity of that push.
- bt_valid  in  1  backtrack request.
- bt_ready  out  1  unit idle, can take a backtrack.
- bt_level  in  LVL_W  target level to keep.
- bt_done  out  1  one-cycle pulse when a backtrack completes.
- clear_valid  out  1  one popped entry this cycle.
- clear_var  out  32  variable id being unassigned.
- clear_value  out  1  polarity it held, for phase saving.
- cur_level  out  LVL_W  current decision level.
- trail_count  out  $clog2(DEPTH)+1  number of valid entries.
- overflow  out  1  sticky; a decision was pushed at level saturation.
- bad_var  out  1  one-cycle pulse; a push was dropped for an illegal id.

Behaviour:
- Storage:
  - trail_var, trail_val and trail_lvl arrays of size DEPTH.
  - level_start array of size DEPTH+1, giving the trail index of the first entry of each level.
- Reset and clear_all (either asserted at a clock edge):
  - state=IDLE, trail_count=0, cur_level=0, overflow=0.
  - All pulse outputs (assign_valid, clear_valid, bt_done, bad_var) are 0.
  - assign_var and clear_var are 0; array contents are don't-care.
  - Reset during UNWIND aborts the unwind with no further clears and no bt_done.
- States: IDLE and UNWIND.
- push_ready = (state==IDLE) && !bt_valid && (trail_count < DEPTH).
  - A backtrack offered in the same cycle as a push takes priority.
- Accepted push (push_valid && push_ready):
  - If push_var==0 or push_var>MAX_VARS: the entry is dropped and bad_var pulses next cycle.
  - Else, if push_is_decision:
    - If cur_level == 2^LVL_W-1: set overflow and drop the push.
    - Otherwise cur_level increments and level_start[new level] = trail_count.
  - The entry is written at index trail_count with the (possibly new) level, and trail_count increments.
  - assign_valid/assign_var/assign_value are asserted exactly 1 cycle after acceptance.
- Back-to-back pushes are allowed, one per cycle.
- When trail_count==DEPTH, push_ready=0 and nothing is overwritten.
- bt_ready = (state==IDLE). A backtrack is accepted when bt_valid && bt_ready.
  - If bt_level >= cur_level: no-op; bt_done pulses the next cycle and the state stays IDLE.
  - Else: target = level_start[bt_level+1], and the unit enters UNWIND the next cycle.
- UNWIND:
  - Each cycle pops the top entry, asserting clear_valid with that entry's var and value, and decrements trail_count.
  - When trail_count reaches target after the pop, cur_level := bt_level, bt_done pulses on the following cycle, and state returns to IDLE.
  - Latency from acceptance to bt_done = (entries popped) + 1 cycles.
  - bt_level=0 unwinds to the level-0 boundary; level-0 implied entries are kept.
  - push and bt inputs are ignored while in UNWIND (ready outputs are low).
- clear_valid and assign_valid never assert in the same cycle.
- All arithmetic is unsigned. Counters never wrap: the full and level-saturation guards above make wrap impossible.

Decomposition:
- Shared package sat_pkg holds:
  - the trail_entry_t struct {var, value, level};
  - typedef level_t of width LVL_W;
  - localparam VAR_NONE = 0.
- Sub-module trail_mem: a single-write, single-read synchronous array indexed by trail position, used for the trail arrays.
- level_start stays a small register file inside trail_stack, because its reads must be combinational.

Test Plan:
- Decision then implication: push decision var 5 value 1, then implied var 9 value 0 -> assign pulses for 5/1 then 9/0 on consecutive cycles; cur_level=1; trail_count=2.
- Multi-level backtrack: push decisions 1, 2, 3, each followed by one implied var (10, 20, 30), then bt_level=1 -> clear_var sequence 30, 3, 20, 2 on 4 consecutive cycles; bt_done on cycle 5; cur_level=1; trail_count=2.
- No-op backtrack: at cur_level=2, bt_level=2 -> no clear_valid; bt_done one cycle later; state unchanged.
- Full trail: DEPTH=4, push 4 implied vars -> push_ready=0; a fifth push is held, not written; trail_count stays 4.
- Illegal id and priority: push var 0 -> bad_var pulse, trail_count unchanged. push_valid and bt_valid in the same cycle -> push_ready=0 and the backtrack proceeds.
- Reset mid-unwind: assert reset_n=0 during the second pop of a 4-entry unwind -> next cycle clear_valid=0, trail_count=0, cur_level=0, no bt_done.
